// File: rtl/arbitrated_memory.sv
// Single-port memory shared by NumOfRequesters masters through a round-robin arbiter.
// One access per clock; read data and per-requester ACK are registered one cycle later.
module arbitrated_memory #(
  parameter int DataWidth       = 8,
  parameter int AddrWidth       = 10,
  parameter int NumOfRequesters = 4
) (
  input  logic                                 CLK,
  input  logic                                 RST_N,
  input  logic [NumOfRequesters-1:0]           REQ,
  input  logic [NumOfRequesters-1:0]           WE,
  input  logic [NumOfRequesters*AddrWidth-1:0] ADDR,
  input  logic [NumOfRequesters*DataWidth-1:0] WDATA,
  output logic [NumOfRequesters-1:0]           GNT,
  output logic [NumOfRequesters-1:0]           ACK,
  output logic [DataWidth-1:0]                 RDATA,
  output logic                                 BUSY
);

  // Handshake: requester i holds REQ[i]/WE[i]/ADDR/WDATA stable until it sees GNT[i]
  // high; the access executes on the edge ending that cycle, and ACK[i] (with RDATA
  // for reads) is valid for exactly the following cycle. GNT alone is not completion.

  localparam int PtrWidth  = $clog2(NumOfRequesters);
  localparam int CandWidth = PtrWidth + 1;
  localparam int Depth     = 2 ** AddrWidth;

  logic [PtrWidth-1:0]        ptr;
  logic [PtrWidth-1:0]        sel_idx;
  logic                       sel_valid;
  logic                       sel_we;
  logic [AddrWidth-1:0]       sel_addr;
  logic [DataWidth-1:0]       sel_wdata;
  logic [NumOfRequesters-1:0] gnt;
  logic [NumOfRequesters-1:0] ack_q;
  logic [DataWidth-1:0]       rdata_q;
  logic [DataWidth-1:0]       mem [Depth];

  // Search requesters starting at ptr, wrapping modulo NumOfRequesters.
  always_comb begin
    logic [CandWidth-1:0] cand;
    gnt       = '0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NumOfRequesters; k++) begin
      cand = {1'b0, ptr} + CandWidth'(k);
      if (cand >= CandWidth'(NumOfRequesters)) begin
        cand = cand - CandWidth'(NumOfRequesters);
      end
      if (!sel_valid && REQ[cand[PtrWidth-1:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[PtrWidth-1:0];
      end
    end
    if (sel_valid) begin
      gnt[sel_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NumOfRequesters; i++) begin
      if (gnt[i]) begin
        sel_we    = WE[i];
        sel_addr  = ADDR[i*AddrWidth +: AddrWidth];
        sel_wdata = WDATA[i*DataWidth +: DataWidth];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr     <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= gnt;
      if (sel_valid) begin
        ptr <= (sel_idx == PtrWidth'(NumOfRequesters - 1)) ? '0 : sel_idx + 1'b1;
        if (!sel_we) begin
          rdata_q <= mem[sel_addr];
        end
      end
    end
  end

  // Array is never reset so its contents survive RST_N; writes are blocked while in reset.
  always_ff @(posedge CLK) begin
    if (RST_N && sel_valid && sel_we) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  assign GNT   = gnt;
  assign ACK   = ack_q;
  assign RDATA = rdata_q;
  assign BUSY  = |REQ;

endmodule

// File: tb/tb_arbitrated_memory.sv
// Bench for arbitrated_memory: directed vector table, hand sequences for reset and a
// second parameter set, then random traffic against a behavioural round-robin model.
module tb_arbitrated_memory;

  localparam int DW  = 8;
  localparam int AW  = 10;
  localparam int NR  = 4;
  localparam int DW2 = 16;
  localparam int AW2 = 4;
  localparam int NR2 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]    req, we, gnt, ack;
  logic [NR*AW-1:0] addr;
  logic [NR*DW-1:0] wdata;
  logic [DW-1:0]    rdata;
  logic             busy;

  logic [NR2-1:0]     req2, we2, gnt2, ack2;
  logic [NR2*AW2-1:0] addr2;
  logic [NR2*DW2-1:0] wdata2;
  logic [DW2-1:0]     rdata2;
  logic               busy2;

  arbitrated_memory #(.DataWidth(DW), .AddrWidth(AW), .NumOfRequesters(NR)) dut (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .WE(we), .ADDR(addr), .WDATA(wdata),
    .GNT(gnt), .ACK(ack), .RDATA(rdata), .BUSY(busy)
  );

  arbitrated_memory #(.DataWidth(DW2), .AddrWidth(AW2), .NumOfRequesters(NR2)) dut2 (
    .CLK(clk), .RST_N(rst_n), .REQ(req2), .WE(we2), .ADDR(addr2), .WDATA(wdata2),
    .GNT(gnt2), .ACK(ack2), .RDATA(rdata2), .BUSY(busy2)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [NR-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] r, input logic [NR-1:0] w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req = r;
    we  = w;
    for (int i = 0; i < NR; i++) begin
      addr[i*AW +: AW]  = a;
      wdata[i*DW +: DW] = d;
    end
  endtask

  task automatic step2(input logic [NR2-1:0] r, input logic [NR2-1:0] w, input logic [DW2-1:0] d,
                       input logic [NR2-1:0] e_gnt, input logic [NR2-1:0] e_ack);
    req2 = r;
    we2  = w;
    for (int i = 0; i < NR2; i++) begin
      addr2[i*AW2 +: AW2]   = 4'hF;
      wdata2[i*DW2 +: DW2]  = d;
    end
    @(negedge clk);
    chk("p2_gnt", 32'(gnt2), 32'(e_gnt));
    chk("p2_ack", 32'(ack2), 32'(e_ack));
    next_cycle();
  endtask

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [NR-1:0] e_gnt;
    logic [NR-1:0] e_ack;
    logic [DW-1:0] e_rd;
  } vec_t;
  vec_t tbl[15];

  // ---------------- reference model state ----------------
  int            m_ptr;
  logic [DW-1:0] m_rdata;
  bit            m_rd_known;
  logic [DW-1:0] ref_mem[8];
  bit            ref_known[8];
  bit            pend[NR];
  logic          p_we[NR];
  logic [AW-1:0] p_addr[NR];
  logic [DW-1:0] p_wd[NR];
  int            waits[NR];

  initial begin
    // write A5 @3FF by req2, read back, skip over idle req3, RAW req1->req3, full contention
    tbl[0]  = '{4'b0100, 4'b0100, 10'h3FF, 8'hA5, 4'b0100, 4'b0000, 8'h00};
    tbl[1]  = '{4'b0100, 4'b0000, 10'h3FF, 8'h00, 4'b0100, 4'b0100, 8'h00};
    tbl[2]  = '{4'b0000, 4'b0000, 10'h000, 8'h00, 4'b0000, 4'b0100, 8'hA5};
    tbl[3]  = '{4'b0101, 4'b0000, 10'h3FF, 8'h00, 4'b0001, 4'b0000, 8'hA5};
    tbl[4]  = '{4'b0100, 4'b0000, 10'h3FF, 8'h00, 4'b0100, 4'b0001, 8'hA5};
    tbl[5]  = '{4'b0001, 4'b0000, 10'h3FF, 8'h00, 4'b0001, 4'b0100, 8'hA5};
    tbl[6]  = '{4'b1010, 4'b0010, 10'h010, 8'h3C, 4'b0010, 4'b0001, 8'hA5};
    tbl[7]  = '{4'b1000, 4'b0000, 10'h010, 8'h00, 4'b1000, 4'b0010, 8'hA5};
    tbl[8]  = '{4'b0000, 4'b0000, 10'h000, 8'h00, 4'b0000, 4'b1000, 8'h3C};
    tbl[9]  = '{4'b1111, 4'b0000, 10'h3FF, 8'h00, 4'b0001, 4'b0000, 8'h3C};
    tbl[10] = '{4'b1111, 4'b0000, 10'h3FF, 8'h00, 4'b0010, 4'b0001, 8'hA5};
    tbl[11] = '{4'b1111, 4'b0000, 10'h3FF, 8'h00, 4'b0100, 4'b0010, 8'hA5};
    tbl[12] = '{4'b1111, 4'b0000, 10'h3FF, 8'h00, 4'b1000, 4'b0100, 8'hA5};
    tbl[13] = '{4'b1111, 4'b0000, 10'h3FF, 8'h00, 4'b0001, 4'b1000, 8'hA5};
    tbl[14] = '{4'b0000, 4'b0000, 10'h000, 8'h00, 4'b0000, 4'b0001, 8'hA5};

    rst_n = 1'b0;
    drive('0, '0, '0, '0);
    req2 = '0; we2 = '0; addr2 = '0; wdata2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack2", 32'(ack2), 32'h0);
    chk("rst_rdata2", 32'(rdata2), 32'h0);
    next_cycle();
    rst_n = 1'b1;

    // second parameter set: contention order 0,1,2,0 then write/read BEEF at address 15
    step2(3'b111, 3'b000, 16'h0000, 3'b001, 3'b000);
    step2(3'b111, 3'b000, 16'h0000, 3'b010, 3'b001);
    step2(3'b111, 3'b000, 16'h0000, 3'b100, 3'b010);
    step2(3'b111, 3'b000, 16'h0000, 3'b001, 3'b100);
    step2(3'b010, 3'b010, 16'hBEEF, 3'b010, 3'b001);
    step2(3'b010, 3'b000, 16'h0000, 3'b010, 3'b010);
    req2 = '0;
    @(negedge clk);
    chk("p2_ack_rd", 32'(ack2), 32'(3'b010));
    chk("p2_rdata", 32'(rdata2), 32'hBEEF);
    next_cycle();

    // directed vector table
    for (int r = 0; r < 15; r++) begin
      drive(tbl[r].req, tbl[r].we, tbl[r].a, tbl[r].wd);
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", r), 32'(gnt), 32'(tbl[r].e_gnt));
      chk($sformatf("tbl%0d_ack", r), 32'(ack), 32'(tbl[r].e_ack));
      chk($sformatf("tbl%0d_rdata", r), 32'(rdata), 32'(tbl[r].e_rd));
      chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].req != 0));
      next_cycle();
    end

    // reset during a read grant: ACK/RDATA clear at once, memory survives
    drive(4'b0001, 4'b0001, 10'h020, 8'h11);
    @(negedge clk);
    chk("rs_wr_gnt", 32'(gnt), 32'(4'b0001));
    next_cycle();
    drive(4'b0010, 4'b0000, 10'h020, 8'h00);
    @(negedge clk);
    chk("rs_rd_gnt", 32'(gnt), 32'(4'b0010));
    chk("rs_wr_ack", 32'(ack), 32'(4'b0001));
    rst_n = 1'b0;
    #1;
    chk("rs_async_ack", 32'(ack), 32'h0);
    chk("rs_async_rdata", 32'(rdata), 32'h0);
    chk("rs_gnt_in_rst", 32'(gnt), 32'(4'b0010));
    chk("rs_busy_in_rst", 32'(busy), 32'h1);
    next_cycle();
    @(negedge clk);
    chk("rs_ack_dropped", 32'(ack), 32'h0);
    chk("rs_rdata_held0", 32'(rdata), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    drive(4'b0010, 4'b0000, 10'h020, 8'h00);
    @(negedge clk);
    chk("rs_post_gnt", 32'(gnt), 32'(4'b0010));
    next_cycle();
    drive('0, '0, '0, '0);
    @(negedge clk);
    chk("rs_post_ack", 32'(ack), 32'(4'b0010));
    chk("rs_post_rdata", 32'(rdata), 32'h11);
    next_cycle();

    // random traffic against the behavioural model
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    m_ptr = 0;
    m_rdata = '0;
    m_rd_known = 1'b1;
    exp_q.push_back('0);
    for (int i = 0; i < 8; i++) ref_known[i] = 1'b0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0;
      waits[i] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      int g;
      logic [NR-1:0] exp_gnt;
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]   = 1'b1;
          p_we[i]   = 1'($urandom_range(0, 1));
          p_addr[i] = AW'($urandom_range(0, 7));
          p_wd[i]   = DW'($urandom);
        end
        req[i] = pend[i];
        we[i]  = pend[i] ? p_we[i] : 1'($urandom_range(0, 1));
        addr[i*AW +: AW]  = pend[i] ? p_addr[i] : AW'($urandom);
        wdata[i*DW +: DW] = pend[i] ? p_wd[i] : DW'($urandom);
      end
      @(negedge clk);
      g = -1;
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && pend[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      end
      exp_gnt = '0;
      if (g >= 0) exp_gnt[g] = 1'b1;
      chk("rnd_gnt", 32'(gnt), 32'(exp_gnt));
      chk("rnd_busy", 32'(busy), 32'(exp_gnt != 0));
      chk("rnd_ack", 32'(ack), 32'(exp_q.pop_front()));
      if (m_rd_known) chk("rnd_rdata", 32'(rdata), 32'(m_rdata));
      for (int i = 0; i < NR; i++) begin
        if (pend[i] && gnt[i]) begin
          chk("rnd_fair", 32'(waits[i] < NR), 32'h1);
          waits[i] = 0;
        end else if (pend[i]) begin
          waits[i]++;
        end
      end
      if (g >= 0) begin
        if (p_we[g]) begin
          ref_mem[p_addr[g][2:0]]   = p_wd[g];
          ref_known[p_addr[g][2:0]] = 1'b1;
        end else begin
          m_rdata    = ref_mem[p_addr[g][2:0]];
          m_rd_known = ref_known[p_addr[g][2:0]];
        end
        m_ptr   = (g + 1) % NR;
        pend[g] = 1'b0;
      end
      exp_q.push_back(exp_gnt);
      next_cycle();
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
